game_audio_sequencer: RTL and testbench

//  Parametrised successor to the fixed-priority event-to-sound mapper between GamePhysics and the

---
 rtl/game_audio_sequencer.sv | 148 ++++++++++++++
 tb/tb_game_audio_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_audio_sequencer.sv
// Event-to-sound sequencer: captures per-step physics events, queues one sample request per event
// in priority order and replays them to the sample player with a trigger/busy handshake.
module game_audio_sequencer #(
  parameter int NUM_EVENTS     = 4,
  parameter int SAMPLE_BITS    = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int PREEMPT_LEVELS = 1,
  parameter int ACK_TIMEOUT    = 15
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              step_complete_i,
  input  logic [NUM_EVENTS-1:0]             event_valid_i,
  input  logic [NUM_EVENTS*SAMPLE_BITS-1:0] event_sample_i,
  input  logic                              audio_busy_i,
  output logic [SAMPLE_BITS-1:0]            audio_select_o,
  output logic                              audio_trigger_o,
  output logic [$clog2(QUEUE_DEPTH):0]      queue_level_o,
  output logic [7:0]                        drop_count_o,
  output logic                              overflow_o
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, PLAYING} state_t;

  state_t                 state_q;
  logic [NUM_EVENTS-1:0]  pending_q, pending_d;
  logic [SAMPLE_BITS-1:0] sample_q [NUM_EVENTS];
  logic [SAMPLE_BITS-1:0] fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [TMR_W-1:0]       timer_q;
  logic                   token_q;
  logic [SAMPLE_BITS-1:0] select_q;
  logic                   trigger_q;
  logic [7:0]             drop_q;
  logic                   overflow_q;

  logic [NUM_EVENTS-1:0]  pre_mask, capture, push_onehot;
  logic [IDX_W-1:0]       push_idx;
  logic                   preempt, push_req, pop, full, push_ok, drop;

  always_comb begin
    pre_mask = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      pre_mask[i] = (i < PREEMPT_LEVELS);
    end
    capture  = step_complete_i ? event_valid_i : '0;
    preempt  = |(capture & pre_mask);
    push_req = |pending_q;
    push_idx = '0;
    // scan high-to-low so the lowest set bit (highest priority) wins
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) push_idx = IDX_W'(i);
    end
    push_onehot = push_req ? (NUM_EVENTS'(1) << push_idx) : '0;
    full    = (level_q == LVL_W'(QUEUE_DEPTH));
    pop     = (state_q == IDLE) && (level_q != '0) && (!audio_busy_i || token_q) && !preempt;
    push_ok = push_req && (!full || pop) && !preempt;
    drop    = push_req && full && !pop && !preempt;
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
    pending_d = preempt ? (capture & pre_mask) : ((pending_q & ~push_onehot) | capture);
  end

  // capture / push stage: pending mask, FIFO pointers and drop accounting
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (preempt) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        level_q <= level_d;
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        if (drop) begin
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
          overflow_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (capture[i]) sample_q[i] <= event_sample_i[i*SAMPLE_BITS +: SAMPLE_BITS];
    end
    if (push_ok) fifo_q[wr_ptr_q] <= sample_q[push_idx];
  end

  // playback stage: pop, trigger and busy handshake
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      token_q   <= 1'b0;
      select_q  <= '0;
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      if (preempt) begin
        state_q <= IDLE;
        timer_q <= '0;
        token_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (pop) begin
              select_q  <= fifo_q[rd_ptr_q];
              trigger_q <= 1'b1;
              token_q   <= 1'b0;
              timer_q   <= '0;
              state_q   <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (audio_busy_i)                          state_q <= PLAYING;
            else if (timer_q == TMR_W'(ACK_TIMEOUT))   state_q <= IDLE;
            else                                       timer_q <= timer_q + 1'b1;
          end
          PLAYING: begin
            if (!audio_busy_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign audio_select_o  = select_q;
  assign audio_trigger_o = trigger_q;
  assign queue_level_o   = level_q;
  assign drop_count_o    = drop_q;
  assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_game_audio_sequencer.sv
// Bench for game_audio_sequencer: table-driven scenarios, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_game_audio_sequencer;
  localparam int ACK_TO = 15;
  localparam int QD     = 4;
  localparam logic [3:0] PMASK = 4'b0001;

  logic        clk = 1'b0;
  logic        rst, step;
  logic [3:0]  ev;
  logic [15:0] samp;
  logic        busy;
  logic [3:0]  sel;
  logic        trig;
  logic [2:0]  lvl;
  logic [7:0]  drops;
  logic        ovf;

  bit          auto_en;
  int          play_len;
  int          pcnt;
  logic        busy_auto, busy_man;
  int          total, bad;
  int          cyc;
  int          tcyc[$];
  logic [3:0]  tsel[$];

  assign busy = auto_en ? busy_auto : busy_man;

  game_audio_sequencer #(
    .NUM_EVENTS(4), .SAMPLE_BITS(4), .QUEUE_DEPTH(QD), .PREEMPT_LEVELS(1), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk_i(clk), .reset_i(rst), .step_complete_i(step), .event_valid_i(ev),
    .event_sample_i(samp), .audio_busy_i(busy), .audio_select_o(sel),
    .audio_trigger_o(trig), .queue_level_o(lvl), .drop_count_o(drops), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig === 1'b1) begin
      tcyc.push_back(cyc);
      tsel.push_back(sel);
    end
  end

  // simple player: goes busy right after a trigger and stays busy for play_len cycles
  always @(negedge clk) begin
    if (rst || !auto_en) begin
      busy_auto = 1'b0;
      pcnt = 0;
    end else if (trig) begin
      busy_auto = 1'b1;
      pcnt = play_len;
    end else if (pcnt > 0) begin
      pcnt--;
      if (pcnt == 0) busy_auto = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; ev = '0; samp = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] e, input logic [15:0] s, output int sc);
    @(negedge clk);
    step = 1'b1; ev = e; samp = s; sc = cyc;
    @(negedge clk);
    step = 1'b0; ev = '0;
  endtask

  task automatic clear_log();
    tcyc.delete();
    tsel.delete();
  endtask

  // reference model: request queue plus the player-handshake rules
  logic [3:0] mq[$];
  logic [3:0] m_pend;
  logic [3:0] m_samp [4];
  int         m_mode;   // 0 idle, 1 waiting for busy, 2 playing
  int         m_timer;
  bit         m_tok;
  bit         m_trig;
  logic [3:0] m_sel;
  int         m_drops;
  bit         m_ovf;

  task automatic m_step(input bit r, input bit stp, input logic [3:0] e, input logic [15:0] s,
                        input bit bsy);
    logic [3:0] cap;
    bit pre, popd;
    int low;
    if (r) begin
      mq.delete(); m_pend = '0; m_mode = 0; m_timer = 0; m_tok = 0;
      m_trig = 0; m_sel = '0; m_drops = 0; m_ovf = 0;
      return;
    end
    cap = stp ? e : 4'b0;
    pre = (cap & PMASK) != 4'b0;
    m_trig = 0;
    if (pre) begin
      mq.delete();
      m_pend = cap & PMASK;
      m_mode = 0;
      m_tok  = 1;
    end else begin
      popd = (m_mode == 0) && (mq.size() > 0) && (!bsy || m_tok);
      if (popd) begin
        m_sel = mq.pop_front(); m_trig = 1; m_tok = 0; m_mode = 1; m_timer = 0;
      end else if (m_mode == 1) begin
        if (bsy) m_mode = 2;
        else if (m_timer == ACK_TO) m_mode = 0;
        else m_timer++;
      end else if (m_mode == 2 && !bsy) begin
        m_mode = 0;
      end
      if (m_pend != 4'b0) begin
        low = 0;
        while (!m_pend[low]) low++;
        if (mq.size() < QD) mq.push_back(m_samp[low]);
        else begin
          if (m_drops < 255) m_drops++;
          m_ovf = 1;
        end
        m_pend[low] = 1'b0;
      end
      m_pend = m_pend | cap;
    end
    for (int i = 0; i < 4; i++) if (cap[i]) m_samp[i] = s[i*4 +: 4];
  endtask

  typedef struct {
    logic [3:0]  ev;
    logic [15:0] samp;
    int          n;
    logic [15:0] exp_sel;   // nibble k = select of trigger k
  } vec_t;
  vec_t vec[7];

  initial begin
    int sc, n0;
    vec[0] = '{4'b0100, 16'h0500, 1, 16'h0005};
    vec[1] = '{4'b1110, 16'h4320, 3, 16'h0432};
    vec[2] = '{4'b0001, 16'h000A, 1, 16'h000A};
    vec[3] = '{4'b1111, 16'hDCBA, 1, 16'h000A};
    vec[4] = '{4'b1000, 16'hF000, 1, 16'h000F};
    vec[5] = '{4'b1010, 16'h7060, 2, 16'h0076};
    vec[6] = '{4'b0000, 16'h1234, 0, 16'h0000};
    total = 0; bad = 0;
    rst = 1'b1; step = 1'b0; ev = '0; samp = '0; busy_man = 1'b0;
    auto_en = 1'b0; play_len = 3;

    do_reset();
    chk("reset trig", int'(trig), 0);
    chk("reset sel", int'(sel), 0);
    chk("reset level", int'(lvl), 0);
    chk("reset drops", int'(drops), 0);
    chk("reset ovf", int'(ovf), 0);

    // table-driven single-strobe scenarios with a cooperative player
    for (int v = 0; v < 7; v++) begin
      auto_en = 1'b1; play_len = 3;
      do_reset();
      clear_log();
      strobe(vec[v].ev, vec[v].samp, sc);
      repeat (80) @(negedge clk);
      chk($sformatf("vec%0d count", v), tcyc.size(), vec[v].n);
      for (int k = 0; k < vec[v].n && k < tcyc.size(); k++)
        chk($sformatf("vec%0d sel%0d", v, k), int'(tsel[k]), int'(vec[v].exp_sel[k*4 +: 4]));
      if (vec[v].n > 0 && tcyc.size() > 0)
        chk($sformatf("vec%0d latency", v), tcyc[0] - sc, 3);
      chk($sformatf("vec%0d level", v), int'(lvl), 0);
      chk($sformatf("vec%0d drops", v), int'(drops), 0);
    end

    // order with a 20-cycle sound: each trigger waits for the previous busy fall
    auto_en = 1'b1; play_len = 20;
    do_reset();
    clear_log();
    strobe(4'b1110, 16'h4320, sc);
    repeat (100) @(negedge clk);
    chk("order count", tcyc.size(), 3);
    if (tcyc.size() == 3) begin
      chk("order sel0", int'(tsel[0]), 2);
      chk("order sel1", int'(tsel[1]), 3);
      chk("order sel2", int'(tsel[2]), 4);
      chk("order gap1", tcyc[1] - tcyc[0], 22);
      chk("order gap2", tcyc[2] - tcyc[1], 22);
    end

    // overflow with the player stuck busy
    auto_en = 1'b0; busy_man = 1'b1;
    do_reset();
    clear_log();
    strobe(4'b1110, 16'h4320, sc);
    repeat (4) @(negedge clk);
    chk("ovf pre level", int'(lvl), 3);
    chk("ovf pre flag", int'(ovf), 0);
    strobe(4'b1110, 16'h4320, sc);
    repeat (4) @(negedge clk);
    strobe(4'b1110, 16'h4320, sc);
    repeat (4) @(negedge clk);
    chk("ovf level", int'(lvl), 4);
    chk("ovf drops", int'(drops), 5);
    chk("ovf flag", int'(ovf), 1);
    chk("ovf no trig", tcyc.size(), 0);

    // preempt while busy with three entries queued
    do_reset();
    clear_log();
    strobe(4'b1110, 16'h4320, sc);
    repeat (4) @(negedge clk);
    chk("pre queued", int'(lvl), 3);
    strobe(4'b0001, 16'h0000, sc);
    chk("pre flushed", int'(lvl), 0);
    repeat (5) @(negedge clk);
    chk("pre count", tcyc.size(), 1);
    if (tcyc.size() == 1) begin
      chk("pre latency", tcyc[0] - sc, 3);
      chk("pre sel", int'(tsel[0]), 0);
    end
    chk("pre drops", int'(drops), 0);
    chk("pre level", int'(lvl), 0);
    clear_log();
    strobe(4'b0001, 16'h0009, sc);
    repeat (5) @(negedge clk);
    chk("pre2 count", tcyc.size(), 1);
    if (tcyc.size() == 1) begin
      chk("pre2 latency", tcyc[0] - sc, 3);
      chk("pre2 sel", int'(tsel[0]), 9);
    end

    // no acknowledge: second trigger after the ack timeout
    busy_man = 1'b0;
    do_reset();
    clear_log();
    strobe(4'b0110, 16'h0870, sc);
    repeat (60) @(negedge clk);
    chk("noack count", tcyc.size(), 2);
    if (tcyc.size() == 2) begin
      chk("noack latency", tcyc[0] - sc, 3);
      chk("noack gap", tcyc[1] - tcyc[0], ACK_TO + 2);
      chk("noack sel0", int'(tsel[0]), 7);
      chk("noack sel1", int'(tsel[1]), 8);
    end

    // reset while waiting for acknowledge with two entries queued
    do_reset();
    clear_log();
    strobe(4'b1110, 16'h4320, sc);
    repeat (3) @(negedge clk);
    chk("rstmid trig seen", tcyc.size(), 1);
    chk("rstmid queued", int'(lvl), 2);
    chk("rstmid sel before", int'(sel), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid trig", int'(trig), 0);
    chk("rstmid sel", int'(sel), 0);
    chk("rstmid level", int'(lvl), 0);
    chk("rstmid drops", int'(drops), 0);
    chk("rstmid ovf", int'(ovf), 0);
    n0 = tcyc.size();
    repeat (50) @(negedge clk);
    chk("rstmid silent", tcyc.size(), n0);

    // randomized run against the reference model
    auto_en = 1'b0; busy_man = 1'b0;
    @(negedge clk);
    rst = 1'b1; step = 1'b0; ev = '0; samp = '0;
    m_step(1'b1, 1'b0, 4'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chk("rnd trig", int'(trig), int'(m_trig));
      chk("rnd sel", int'(sel), int'(m_sel));
      chk("rnd level", int'(lvl), mq.size());
      chk("rnd drops", int'(drops), m_drops);
      chk("rnd ovf", int'(ovf), int'(m_ovf));
      rst  = ($urandom_range(0, 199) == 0);
      step = ($urandom_range(0, 99) < 30);
      ev   = (4'($urandom()) & 4'hE) | {3'b0, ($urandom_range(0, 19) == 0)};
      samp = 16'($urandom());
      if ($urandom_range(0, 9) == 0) busy_man = ~busy_man;
      m_step(rst, step, ev, samp, busy_man);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
